// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and widths, used by the PC, fetch and decode stages.
package cpu_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned FETCH_DEPTH = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with push/pop/clear; head comes straight from storage (no bypass).
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  parameter type T = fetch_entry_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  T                 data_in,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Reset also wipes storage so the head reads zero afterwards; clear keeps stale contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: takes PCs, reads the synchronous ROM, and queues {instr, pc} for decode.
module instr_fetch_queue #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned DEPTH   = cpu_pkg::FETCH_DEPTH
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  input  logic [ADDR_W-1:0]  i_PC,
  input  logic               i_PC_VALID,
  output logic               o_PC_READY,
  output logic [ADDR_W-1:0]  o_MEM_ADDR,
  output logic               o_MEM_RD,
  input  logic [INSTR_W-1:0] i_MEM_DATA,
  input  logic               i_FLUSH,
  output logic [INSTR_W-1:0] o_INSTR,
  output logic [ADDR_W-1:0]  o_INSTR_PC,
  output logic               o_INSTR_VALID,
  input  logic               i_INSTR_READY
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic              pending;
  logic [ADDR_W-1:0] pending_pc;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              pop;
  logic              push;
  entry_t            wr_entry;
  entry_t            head;

  // The in-flight read holds a credit, so a data return can never land on a full queue.
  assign o_PC_READY = i_RESET & ~i_FLUSH &
                      ((SUM_W'(count) + SUM_W'(pending)) < SUM_W'(DEPTH));
  assign accept     = i_PC_VALID & o_PC_READY;
  assign o_MEM_ADDR = i_PC;
  assign o_MEM_RD   = accept;

  assign o_INSTR_VALID = (count != '0);
  assign pop           = o_INSTR_VALID & i_INSTR_READY & ~i_FLUSH;
  assign push          = pending & ~i_FLUSH;
  assign wr_entry      = '{instr: i_MEM_DATA, pc: pending_pc};

  // Tracks the single read whose ROM data returns on the next edge.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      pending    <= 1'b0;
      pending_pc <= '0;
    end else begin
      pending <= accept;
      if (accept) begin
        pending_pc <= i_PC;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (i_CLK),
    .rst_n   (i_RESET),
    .clear   (i_FLUSH),
    .push    (push),
    .data_in (wr_entry),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  assign o_INSTR    = head.instr;
  assign o_INSTR_PC = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc;
  logic        pc_valid;
  logic        pc_ready;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        flush;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .i_CLK         (clk),
    .i_RESET       (rst_n),
    .i_PC          (pc),
    .i_PC_VALID    (pc_valid),
    .o_PC_READY    (pc_ready),
    .o_MEM_ADDR    (mem_addr),
    .o_MEM_RD      (mem_rd),
    .i_MEM_DATA    (mem_data),
    .i_FLUSH       (flush),
    .o_INSTR       (instr),
    .o_INSTR_PC    (instr_pc),
    .o_INSTR_VALID (instr_valid),
    .i_INSTR_READY (instr_ready)
  );

  function automatic logic [15:0] rom(input logic [7:0] a);
    return 16'hA000 + {8'h00, a};
  endfunction

  // Synchronous ROM; garbage on cycles without a read so stray writes get noticed.
  always @(posedge clk) mem_data <= mem_rd ? rom(mem_addr) : 16'($urandom);

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  pc;
  } ent_t;

  typedef struct {
    bit          ready;
    bit          valid;
    logic [15:0] instr;
    logic [7:0]  ipc;
    bit          mem_rd;
    logic [7:0]  maddr;
    bit          accept;
    bit          pop;
  } snap_t;

  // Reference: queue of delivered-but-unconsumed words plus at most one outstanding ROM read.
  ent_t       mq[$];
  bit         m_infl = 1'b0;
  logic [7:0] m_infl_pc = 8'h00;

  task automatic tick(input bit r_n, input bit fl, input bit pv, input logic [7:0] p,
                      input bit ird, output snap_t o, output snap_t e);
    rst_n = r_n; flush = fl; pc_valid = pv; pc = p; instr_ready = ird;
    #1;
    o.ready  = pc_ready;
    o.valid  = instr_valid;
    o.instr  = instr;
    o.ipc    = instr_pc;
    o.mem_rd = mem_rd;
    o.maddr  = mem_addr;
    o.accept = pv & pc_ready;
    o.pop    = instr_valid & ird;
    e.ready  = r_n && !fl && (mq.size() + int'(m_infl) < DEPTH);
    e.valid  = mq.size() != 0;
    e.instr  = e.valid ? mq[0].instr : 16'h0000;
    e.ipc    = e.valid ? mq[0].pc : 8'h00;
    e.mem_rd = pv && e.ready;
    e.maddr  = p;
    e.accept = e.mem_rd;
    e.pop    = e.valid && ird && !fl;
    @(posedge clk);
    if (!r_n || fl) begin
      mq.delete();
      m_infl = 1'b0;
    end else begin
      if (e.pop) void'(mq.pop_front());
      if (m_infl) mq.push_back('{rom(m_infl_pc), m_infl_pc});
      m_infl = e.accept;
      if (e.accept) m_infl_pc = p;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    snap_t o, e;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, o, e);
      checks++; if (o.ready !== 1'b0) begin failures++; $display("FAIL reset_ready cyc=%0d got=%b exp=0", cyc, o.ready); end
      checks++; if (o.mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd cyc=%0d got=%b exp=0", cyc, o.mem_rd); end
      if (i > 0) begin
        checks++; if (o.valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", cyc, o.valid); end
        checks++; if (o.instr !== 16'h0000) begin failures++; $display("FAIL reset_instr cyc=%0d got=%h exp=0000", cyc, o.instr); end
        checks++; if (o.ipc !== 8'h00) begin failures++; $display("FAIL reset_pc cyc=%0d got=%h exp=00", cyc, o.ipc); end
      end
    end
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, o, e);
    checks++; if (o.ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", o.ready); end
    checks++; if ({o.valid, o.instr, o.ipc} !== 25'h0) begin failures++; $display("FAIL post_reset_head got=%b/%h/%h exp=0/0000/00", o.valid, o.instr, o.ipc); end
  endtask

  task automatic test_stream();
    snap_t o, e;
    ent_t got[$];
    int k = 0, first_acc = -1, first_val = -1, first_pop = -1, last_pop = -1;
    for (int g = 0; g < 30 && got.size() < 8; g++) begin
      int c;
      c = cyc;
      tick(1'b1, 1'b0, k < 8, 8'(k), 1'b1, o, e);
      checks++; if (o.ready !== e.ready) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", c, o.ready, e.ready); end
      checks++; if (o.valid !== e.valid) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, o.valid, e.valid); end
      if (e.valid) begin
        checks++; if ({o.instr, o.ipc} !== {e.instr, e.ipc}) begin failures++; $display("FAIL stream_head cyc=%0d got=%h/%h exp=%h/%h", c, o.instr, o.ipc, e.instr, e.ipc); end
      end
      if (e.accept) begin if (first_acc < 0) first_acc = c; k++; end
      if (o.valid && first_val < 0) first_val = c;
      if (o.pop) begin got.push_back('{o.instr, o.ipc}); if (first_pop < 0) first_pop = c; last_pop = c; end
    end
    checks++; if (first_val - first_acc !== 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", first_val - first_acc); end
    checks++; if (got.size() !== 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", got.size()); end
    checks++; if (last_pop - first_pop !== 7) begin failures++; $display("FAIL stream_gapless got=%0d exp=7", last_pop - first_pop); end
    for (int j = 0; j < got.size(); j++) begin
      ent_t x;
      x = '{16'(16'hA000 + j), 8'(j)};
      checks++; if (got[j] !== x) begin failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", j, got[j], x); end
    end
  endtask

  task automatic test_backpressure();
    snap_t o, e;
    logic [7:0] acc[$];
    ent_t got[$];
    int k = 0;
    for (int g = 0; g < 8; g++) begin
      tick(1'b1, 1'b0, 1'b1, 8'(16 + k), 1'b0, o, e);
      checks++; if (o.ready !== e.ready) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, o.ready, e.ready); end
      if (o.accept) acc.push_back(o.maddr);
      if (e.accept) k++;
    end
    checks++; if (acc.size() !== 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", acc.size()); end
    checks++; if (o.ready !== 1'b0) begin failures++; $display("FAIL bp_stalled got=%b exp=0", o.ready); end
    for (int g = 0; g < 40 && got.size() < 8; g++) begin
      tick(1'b1, 1'b0, k < 8, 8'(16 + k), 1'b1, o, e);
      checks++; if (o.ready !== e.ready) begin failures++; $display("FAIL bp_ready2 cyc=%0d got=%b exp=%b", cyc, o.ready, e.ready); end
      if (e.valid) begin
        checks++; if ({o.valid, o.instr, o.ipc} !== {1'b1, e.instr, e.ipc}) begin failures++; $display("FAIL bp_head cyc=%0d got=%b/%h/%h exp=1/%h/%h", cyc, o.valid, o.instr, o.ipc, e.instr, e.ipc); end
      end
      if (o.accept) acc.push_back(o.maddr);
      if (o.pop) got.push_back('{o.instr, o.ipc});
      if (e.accept) k++;
    end
    checks++; if (acc.size() !== 8) begin failures++; $display("FAIL bp_total_accepts got=%0d exp=8", acc.size()); end
    for (int j = 0; j < acc.size(); j++) begin
      checks++; if (acc[j] !== 8'(16 + j)) begin failures++; $display("FAIL bp_accept_order idx=%0d got=%h exp=%h", j, acc[j], 8'(16 + j)); end
    end
    checks++; if (got.size() !== 8) begin failures++; $display("FAIL bp_pops got=%0d exp=8", got.size()); end
    for (int j = 0; j < got.size(); j++) begin
      checks++; if (got[j].pc !== 8'(16 + j) || got[j].instr !== 16'(16'hA010 + j)) begin failures++; $display("FAIL bp_drain_order idx=%0d got=%h exp=%h/%h", j, got[j], 16'(16'hA010 + j), 8'(16 + j)); end
    end
  endtask

  task automatic test_flush();
    snap_t o, e;
    tick(1'b1, 1'b0, 1'b1, 8'h20, 1'b0, o, e);
    tick(1'b1, 1'b0, 1'b1, 8'h21, 1'b0, o, e);
    tick(1'b1, 1'b1, 1'b1, 8'h30, 1'b1, o, e);
    checks++; if (o.ready !== 1'b0 || o.mem_rd !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%b/%b exp=0/0", o.ready, o.mem_rd); end
    tick(1'b1, 1'b0, 1'b1, 8'h40, 1'b0, o, e);
    checks++; if (o.valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", o.valid); end
    checks++; if (o.accept !== 1'b1) begin failures++; $display("FAIL flush_reaccept got=%b exp=1", o.accept); end
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, o, e);
    checks++; if (o.valid !== 1'b0) begin failures++; $display("FAIL flush_latency1 got=%b exp=0", o.valid); end
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, o, e);
    checks++; if ({o.valid, o.instr, o.ipc} !== {1'b1, 16'hA040, 8'h40}) begin failures++; $display("FAIL flush_next got=%b/%h/%h exp=1/a040/40", o.valid, o.instr, o.ipc); end
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, o, e);
    checks++; if (o.valid !== 1'b0) begin failures++; $display("FAIL flush_no_stale got=%b exp=0", o.valid); end
  endtask

  task automatic test_full_boundary();
    snap_t o, e;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 1'b1, 8'(8'h50 + k), 1'b0, o, e);
      checks++; if (o.accept !== 1'b1) begin failures++; $display("FAIL full_fill idx=%0d got=%b exp=1", k, o.accept); end
    end
    tick(1'b1, 1'b0, 1'b1, 8'h54, 1'b1, o, e);
    checks++; if (o.ready !== 1'b0) begin failures++; $display("FAIL full_pop_same_cycle got=%b exp=0", o.ready); end
    checks++; if ({o.valid, o.ipc} !== {1'b1, 8'h50}) begin failures++; $display("FAIL full_head got=%b/%h exp=1/50", o.valid, o.ipc); end
    tick(1'b1, 1'b0, 1'b1, 8'h54, 1'b0, o, e);
    checks++; if (o.ready !== 1'b1) begin failures++; $display("FAIL full_ready_next got=%b exp=1", o.ready); end
    for (int g = 0; g < 12 && (e.valid || m_infl); g++) begin
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, o, e);
      checks++; if ({o.valid, e.valid ? {o.instr, o.ipc} : 24'h0} !== {e.valid, e.instr, e.ipc}) begin failures++; $display("FAIL full_drain cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, o.valid, o.instr, o.ipc, e.valid, e.instr, e.ipc); end
    end
  endtask

  task automatic test_wrap();
    snap_t o, e;
    ent_t got[$];
    int k = 0;
    for (int g = 0; g < 300 && got.size() < 12; g++) begin
      tick(1'b1, 1'b0, (k < 12) && ($urandom_range(3) != 0), 8'(8'h60 + k), $urandom_range(1) == 1, o, e);
      checks++; if (o.ready !== e.ready) begin failures++; $display("FAIL wrap_ready cyc=%0d got=%b exp=%b", cyc, o.ready, e.ready); end
      if (o.pop) got.push_back('{o.instr, o.ipc});
      if (e.accept) k++;
    end
    checks++; if (got.size() !== 12) begin failures++; $display("FAIL wrap_count got=%0d exp=12", got.size()); end
    for (int j = 0; j < got.size(); j++) begin
      checks++; if (got[j] !== {16'(16'hA060 + j), 8'(8'h60 + j)}) begin failures++; $display("FAIL wrap_order idx=%0d got=%h exp=%h/%h", j, got[j], 16'(16'hA060 + j), 8'(8'h60 + j)); end
    end
  endtask

  task automatic test_random();
    snap_t o, e;
    for (int g = 0; g < 400; g++) begin
      tick($urandom_range(49) != 0, $urandom_range(9) == 0, $urandom_range(1) == 1,
           8'($urandom), $urandom_range(2) != 0, o, e);
      checks++; if ({o.ready, o.mem_rd, o.maddr} !== {e.ready, e.mem_rd, e.maddr}) begin failures++; $display("FAIL rand_issue cyc=%0d got=%b/%b/%h exp=%b/%b/%h", cyc, o.ready, o.mem_rd, o.maddr, e.ready, e.mem_rd, e.maddr); end
      checks++; if (o.valid !== e.valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, o.valid, e.valid); end
      if (e.valid) begin
        checks++; if ({o.instr, o.ipc} !== {e.instr, e.ipc}) begin failures++; $display("FAIL rand_head cyc=%0d got=%h/%h exp=%h/%h", cyc, o.instr, o.ipc, e.instr, e.ipc); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    snap_t o, e;
    tick(1'b1, 1'b0, 1'b1, 8'h70, 1'b0, o, e);
    tick(1'b1, 1'b0, 1'b1, 8'h71, 1'b0, o, e);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, o, e);
    checks++; if ({o.valid, o.ipc} !== {1'b1, 8'h70}) begin failures++; $display("FAIL mid_filled got=%b/%h exp=1/70", o.valid, o.ipc); end
    tick(1'b0, 1'b0, 1'b1, 8'h72, 1'b1, o, e);
    checks++; if (o.ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b exp=0", o.ready); end
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, o, e);
    checks++; if ({o.valid, o.instr, o.ipc} !== 25'h0) begin failures++; $display("FAIL mid_reset_cleared got=%b/%h/%h exp=0/0000/00", o.valid, o.instr, o.ipc); end
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, o, e);
    checks++; if (o.valid !== 1'b0) begin failures++; $display("FAIL mid_reset_no_late_write got=%b exp=0", o.valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; pc_valid = 1'b0; pc = 8'h00; instr_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_full_boundary();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Consumer end of the program-counter address stream.
- Accepts PC values via valid/ready, issues a read to the synchronous instruction ROM for each one, and queues the returned instruction words, tagged with their PC, for the decoder.
- Supports pipeline flush on branch/jump: drops all queued and in-flight fetches.
- Sits between the PC and the decode stage.

Parameters:
- ADDR_W, 8, PC/ROM address width.
- INSTR_W, 16, instruction word width.
- DEPTH, 4, queue entries (power of two, ≥2).

Ports:
- i_CLK  in  1  clock; all state updates on posedge.
- i_RESET  in  1  synchronous reset, active low.
- i_PC  in  ADDR_W  fetch address offered by the PC.
- i_PC_VALID  in  1  i_PC is valid this cycle.
- o_PC_READY  out  1  queue can accept i_PC this cycle.
- o_MEM_ADDR  out  ADDR_W  ROM address (combinational = i_PC).
- o_MEM_RD  out  1  ROM read strobe (combinational = accept).
- i_MEM_DATA  in  INSTR_W  ROM data, valid the cycle after o_MEM_RD.
- i_FLUSH  in  1  discard all queued and in-flight fetches.
- o_INSTR  out  INSTR_W  head-of-queue instruction.
- o_INSTR_PC  out  ADDR_W  PC tag of o_INSTR.
- o_INSTR_VALID  out  1  head entry valid.
- i_INSTR_READY  in  1  decoder consumes head this cycle.

Behaviour:
- Clock and reset: everything is clocked on posedge i_CLK. Reset is synchronous: it is sampled only on posedge, and i_RESET=0 has priority over every other input.
- Reset state:
  - count=0, rd/wr pointers=0, pending=0, pending_pc=0.
  - o_INSTR_VALID=0; o_INSTR and o_INSTR_PC read 0 when empty after reset.
  - o_PC_READY=0 during the reset cycle.
- Handshake terms:
  - accept = i_PC_VALID & o_PC_READY.
  - pop = o_INSTR_VALID & i_INSTR_READY.
- Ready rule: o_PC_READY = i_RESET & ~i_FLUSH & (count + pending < DEPTH).
  - The rule is conservative: a pop in the same cycle does not free a slot until the next cycle.
- Read issue: o_MEM_ADDR = i_PC and o_MEM_RD = accept, both combinational.
- Accept at edge E0: pending<=1, pending_pc<=i_PC.
- Edge E1 (data return): if pending and not flushed, write {i_MEM_DATA, pending_pc} into the queue at wr_ptr. pending<=accept at E1, so back-to-back accepts sustain one fetch per cycle.
- Latency: PC accepted at E0 → o_INSTR_VALID=1 after E1 (2 edges), provided the queue was empty.
- Queue behaviour:
  - FIFO order is preserved; pointers wrap modulo DEPTH.
  - count <= count + write − pop.
  - A simultaneous write and pop leaves count unchanged.
  - The ready rule guarantees a write never hits a full queue.
- Outputs: o_INSTR_VALID = (count≠0). o_INSTR/o_INSTR_PC come straight from entry rd_ptr (registered storage, no bypass). Their contents are don't-care when invalid, except after reset.
- Flush (i_FLUSH=1 at an edge):
  - count<=0, pointers<=0, pending<=0.
  - ROM data returning that edge is discarded.
  - No accept occurs that cycle (o_PC_READY=0).
  - A pop asserted in the same cycle is ignored.
- Reset mid-operation: identical to flush, plus the stored tags are cleared.
- Width rules:
  - count is clog2(DEPTH)+1 bits.
  - count+pending is compared without overflow.
  - PC tags are stored unmodified; no arithmetic is applied to addresses.

Decomposition:
- Shared package cpu_pkg:
  - Constants ADDR_W=8 and INSTR_W=16, also used by the PC and decode stages.
  - Typedef fetch_entry_t {instr, pc}.
- One sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO with push/pop/clear, count, head data, no bypass. The top level holds the pending/credit logic and the ROM interface.

Test Plan:
- Reset held 3 cycles with i_PC_VALID=1 → o_PC_READY=0, o_MEM_RD=0, o_INSTR_VALID=0, o_INSTR=0, o_INSTR_PC=0.
- Streaming: PC 0x00..0x07 on consecutive cycles, ROM[a]=0xA000+a, i_INSTR_READY=1 → first valid 2 edges after the first accept; then one instruction per cycle, pairs (0xA000,0x00)…(0xA007,0x07) in order, no gaps.
- Backpressure: i_INSTR_READY=0 with PC 0x10.. offered continuously → exactly 4 accepts (0x10–0x13), then o_PC_READY=0. Raise ready → the queue drains 0x10,0x11,… and accepts resume at 0x14 with no loss or duplication.
- Flush with data in flight: accept 0x20 and 0x21, assert i_FLUSH on the edge returning 0x21's data → queue empty and o_INSTR_VALID=0 next cycle. Next accept 0x40 → its instruction, tag 0x40, arrives 2 edges later.
- Full-queue boundary: count=3, pending=1, simultaneous pop → o_PC_READY stays 0 that cycle and becomes 1 the next. Count never exceeds 4.
- Wrap-around: stream 12 PCs with intermittent pops → all 12 tags leave in order across 3 pointer wraps.
